// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the rename-aware register file. The ROB and the
//   reservation stations import the same package so that they agree on word
//   width, register index width, ROB tag width and the "no producer" tag.
//   No ports: package only.
package regfile_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int ROB_DEPTH = 16;
    localparam int REGW      = $clog2(NREGS);
    localparam int TAGW      = $clog2(ROB_DEPTH);

    // Tag reported for a register that has no pending producer.
    localparam logic [TAGW-1:0] ZERO_TAG = '0;

endpackage

// File: rtl/regfile_rename_if.sv
// regfile_rename_if
//   Bundles the read, issue, commit and flush signals of regfile_rename.
//   master : the pipeline side (drives indices/issue/commit/flush, reads values)
//   slave  : the register file itself
//   Signals:
//     rdy_in                     global stall, 0 = no state change
//     rd_idx_in  [NRP*REGW]      read indices, port p at [p*REGW +: REGW]
//     rd_val_out [NRP*XLEN]      read value (or bypassed commit value)
//     rd_busy_out[NRP]           value still pending in the ROB
//     rd_tag_out [NRP*TAGW]      ROB tag to wait on, 0 when not busy
//     issue_en_in/rd/tag         allocate a destination register to a ROB entry
//     commit_en/we/rd/tag/val    retire a result into the register file
//     flush_in                   drop all rename state
interface regfile_rename_if #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int ROB_DEPTH = 16,
    parameter int NRP       = 2
);
    localparam int REGW = $clog2(NREGS);
    localparam int TAGW = $clog2(ROB_DEPTH);

    logic                 rdy_in;
    logic [NRP*REGW-1:0]  rd_idx_in;
    logic [NRP*XLEN-1:0]  rd_val_out;
    logic [NRP-1:0]       rd_busy_out;
    logic [NRP*TAGW-1:0]  rd_tag_out;
    logic                 issue_en_in;
    logic [REGW-1:0]      issue_rd_in;
    logic [TAGW-1:0]      issue_tag_in;
    logic                 commit_en_in;
    logic                 commit_we_in;
    logic [REGW-1:0]      commit_rd_in;
    logic [TAGW-1:0]      commit_tag_in;
    logic [XLEN-1:0]      commit_val_in;
    logic                 flush_in;

    modport master (
        output rdy_in, rd_idx_in,
        output issue_en_in, issue_rd_in, issue_tag_in,
        output commit_en_in, commit_we_in, commit_rd_in, commit_tag_in, commit_val_in,
        output flush_in,
        input  rd_val_out, rd_busy_out, rd_tag_out
    );

    modport slave (
        input  rdy_in, rd_idx_in,
        input  issue_en_in, issue_rd_in, issue_tag_in,
        input  commit_en_in, commit_we_in, commit_rd_in, commit_tag_in, commit_val_in,
        input  flush_in,
        output rd_val_out, rd_busy_out, rd_tag_out
    );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port
//   One combinational read port. Takes the stored entry already selected by
//   the top level and applies the register-0 override and the same-cycle
//   commit bypass.
//   Ports:
//     idx_in           register index being read
//     stored_*_in      val/busy/tag currently held for idx_in
//     commit_vld_in    a writing commit takes effect this cycle (stall-qualified)
//     commit_rd/tag/val_in  that commit's destination, tag and result
//     val/busy/tag_out read result
module regfile_read_port #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int TAGW = 4
) (
    input  logic [REGW-1:0] idx_in,
    input  logic [XLEN-1:0] stored_val_in,
    input  logic            stored_busy_in,
    input  logic [TAGW-1:0] stored_tag_in,
    input  logic            commit_vld_in,
    input  logic [REGW-1:0] commit_rd_in,
    input  logic [TAGW-1:0] commit_tag_in,
    input  logic [XLEN-1:0] commit_val_in,
    output logic [XLEN-1:0] val_out,
    output logic            busy_out,
    output logic [TAGW-1:0] tag_out
);
    import regfile_pkg::*;

    always_comb begin
        val_out  = stored_val_in;
        busy_out = stored_busy_in;
        tag_out  = stored_tag_in;
        if (idx_in == '0) begin
            val_out  = '0;
            busy_out = 1'b0;
            tag_out  = TAGW'(ZERO_TAG);
        end else if (stored_busy_in && commit_vld_in &&
                     commit_rd_in == idx_in && commit_tag_in == stored_tag_in) begin
            // The producer we would wait on is retiring right now: hand its
            // result straight through so the consumer need not wait a cycle.
            val_out  = commit_val_in;
            busy_out = 1'b0;
            tag_out  = TAGW'(ZERO_TAG);
        end
    end

endmodule

// File: rtl/regfile_rename.sv
// regfile_rename
//   Architectural register file with per-register rename state (busy + ROB
//   tag). Issue marks a destination pending on a ROB entry, commit writes the
//   value and releases the register if the committing entry is still its
//   newest producer, flush drops all pending state.
//   Ports:
//     clk_in    clock, all updates on the rising edge
//     rst_n_in  synchronous active-low reset (clears values and rename state)
//     rf        regfile_rename_if.slave bundle (reads, issue, commit, flush)
module regfile_rename #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int ROB_DEPTH = 16,
    parameter int NRP       = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    regfile_rename_if.slave   rf
);
    import regfile_pkg::*;

    localparam int REGW = $clog2(NREGS);
    localparam int TAGW = $clog2(ROB_DEPTH);

    logic [XLEN-1:0]  val_q  [NREGS];
    logic [XLEN-1:0]  val_d  [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [TAGW-1:0]  tag_q  [NREGS];
    logic [TAGW-1:0]  tag_d  [NREGS];

    logic commit_vld;   // writing commit this cycle, any rd
    logic commit_wr;    // ... and it targets a real register
    logic issue_ok;

    assign commit_vld = rf.rdy_in & rf.commit_en_in & rf.commit_we_in;
    assign commit_wr  = commit_vld & (rf.commit_rd_in != '0);
    assign issue_ok   = rf.rdy_in & rf.issue_en_in & (rf.issue_rd_in != '0) & ~rf.flush_in;

    // Update order matters: commit release, then flush, then issue, so that a
    // same-cycle issue overrides the commit's release of the same register.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;

        if (commit_wr) begin
            val_d[rf.commit_rd_in] = rf.commit_val_in;
            // Only release if the committing entry is still the newest
            // producer; otherwise a younger writer owns the register.
            if (busy_q[rf.commit_rd_in] && tag_q[rf.commit_rd_in] == rf.commit_tag_in) begin
                busy_d[rf.commit_rd_in] = 1'b0;
                tag_d[rf.commit_rd_in]  = TAGW'(ZERO_TAG);
            end
        end

        if (rf.rdy_in && rf.flush_in) begin
            busy_d = '0;
            for (int i = 0; i < NREGS; i++) begin
                tag_d[i] = TAGW'(ZERO_TAG);
            end
        end

        if (issue_ok) begin
            busy_d[rf.issue_rd_in] = 1'b1;
            tag_d[rf.issue_rd_in]  = rf.issue_tag_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NREGS; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rp
        logic [REGW-1:0] idx;
        logic [XLEN-1:0] port_val;
        logic            port_busy;
        logic [TAGW-1:0] port_tag;

        assign idx = rf.rd_idx_in[p*REGW +: REGW];

        regfile_read_port #(
            .XLEN (XLEN),
            .REGW (REGW),
            .TAGW (TAGW)
        ) u_rp (
            .idx_in         (idx),
            .stored_val_in  (val_q[idx]),
            .stored_busy_in (busy_q[idx]),
            .stored_tag_in  (tag_q[idx]),
            .commit_vld_in  (commit_vld),
            .commit_rd_in   (rf.commit_rd_in),
            .commit_tag_in  (rf.commit_tag_in),
            .commit_val_in  (rf.commit_val_in),
            .val_out        (port_val),
            .busy_out       (port_busy),
            .tag_out        (port_tag)
        );

        assign rf.rd_val_out[p*XLEN +: XLEN] = port_val;
        assign rf.rd_busy_out[p]             = port_busy;
        assign rf.rd_tag_out[p*TAGW +: TAGW] = port_tag;
    end

endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename
//   Directed scenarios with literal expectations, then randomized traffic
//   compared every cycle against a behavioural model of the register file.
module tb_regfile_rename;
    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int ROB_DEPTH = 16;
    localparam int NRP       = 2;
    localparam int REGW      = 5;
    localparam int TAGW      = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_rename_if #(.XLEN(XLEN), .NREGS(NREGS), .ROB_DEPTH(ROB_DEPTH), .NRP(NRP)) bus ();

    regfile_rename #(.XLEN(XLEN), .NREGS(NREGS), .ROB_DEPTH(ROB_DEPTH), .NRP(NRP)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rf       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model of the architectural state.
    logic [XLEN-1:0] m_val  [NREGS];
    logic            m_busy [NREGS];
    logic [TAGW-1:0] m_tag  [NREGS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_val[i]  <= '0;
                m_busy[i] <= 1'b0;
                m_tag[i]  <= '0;
            end
        end else if (bus.rdy_in) begin
            if (bus.commit_en_in && bus.commit_we_in && bus.commit_rd_in != 0) begin
                m_val[bus.commit_rd_in] <= bus.commit_val_in;
                if (m_busy[bus.commit_rd_in] && m_tag[bus.commit_rd_in] == bus.commit_tag_in) begin
                    m_busy[bus.commit_rd_in] <= 1'b0;
                    m_tag[bus.commit_rd_in]  <= '0;
                end
            end
            if (bus.flush_in) begin
                for (int i = 0; i < NREGS; i++) begin
                    m_busy[i] <= 1'b0;
                    m_tag[i]  <= '0;
                end
            end else if (bus.issue_en_in && bus.issue_rd_in != 0) begin
                m_busy[bus.issue_rd_in] <= 1'b1;
                m_tag[bus.issue_rd_in]  <= bus.issue_tag_in;
            end
        end
    end

    task automatic exp_read(input logic [REGW-1:0] idx, output logic [XLEN-1:0] v,
                            output logic b, output logic [TAGW-1:0] t);
        if (idx == 0) begin
            v = '0; b = 1'b0; t = '0;
        end else if (bus.rdy_in && bus.commit_en_in && bus.commit_we_in && m_busy[idx] &&
                     bus.commit_rd_in == idx && bus.commit_tag_in == m_tag[idx]) begin
            v = bus.commit_val_in; b = 1'b0; t = '0;
        end else begin
            v = m_val[idx]; b = m_busy[idx]; t = m_tag[idx];
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [XLEN-1:0] ev;
        logic            eb;
        logic [TAGW-1:0] et;
        if (chk_en) begin
            for (int p = 0; p < NRP; p++) begin
                exp_read(bus.rd_idx_in[p*REGW +: REGW], ev, eb, et);
                check($sformatf("model_val_p%0d", p), bus.rd_val_out[p*XLEN +: XLEN], ev);
                check($sformatf("model_busy_p%0d", p), {31'd0, bus.rd_busy_out[p]}, {31'd0, eb});
                check($sformatf("model_tag_p%0d", p), {28'd0, bus.rd_tag_out[p*TAGW +: TAGW]}, {28'd0, et});
            end
        end
    end

    task automatic idle();
        bus.rdy_in        = 1'b1;
        bus.issue_en_in   = 1'b0;
        bus.issue_rd_in   = '0;
        bus.issue_tag_in  = '0;
        bus.commit_en_in  = 1'b0;
        bus.commit_we_in  = 1'b0;
        bus.commit_rd_in  = '0;
        bus.commit_tag_in = '0;
        bus.commit_val_in = '0;
        bus.flush_in      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int rd, input int tag);
        bus.issue_en_in  = 1'b1;
        bus.issue_rd_in  = REGW'(rd);
        bus.issue_tag_in = TAGW'(tag);
    endtask

    task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] val);
        bus.commit_en_in  = 1'b1;
        bus.commit_we_in  = 1'b1;
        bus.commit_rd_in  = REGW'(rd);
        bus.commit_tag_in = TAGW'(tag);
        bus.commit_val_in = val;
    endtask

    task automatic set_rd(input int p, input int idx);
        bus.rd_idx_in[p*REGW +: REGW] = REGW'(idx);
    endtask

    task automatic lit(input string name, input int p, input logic [XLEN-1:0] ev,
                       input logic eb, input logic [TAGW-1:0] et);
        check({name, "_val"}, bus.rd_val_out[p*XLEN +: XLEN], ev);
        check({name, "_busy"}, {31'd0, bus.rd_busy_out[p]}, {31'd0, eb});
        check({name, "_tag"}, {28'd0, bus.rd_tag_out[p*TAGW +: TAGW]}, {28'd0, et});
    endtask

    initial begin
        idle();
        bus.rd_idx_in = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset state
        set_rd(0, 5);
        sample(); lit("reset_x5", 0, 32'h0, 1'b0, 4'd0);

        // Rename then release
        tick(); issue(3, 4);
        tick(); idle(); set_rd(0, 3);
        sample(); lit("issue_x3", 0, 32'h0, 1'b1, 4'd4);
        tick(); commit(3, 4, 32'hDEADBEEF);
        tick(); idle();
        sample(); lit("release_x3", 0, 32'hDEADBEEF, 1'b0, 4'd0);
        check("model_pin_x3", m_val[3], 32'hDEADBEEF);

        // Stale commit
        tick(); issue(7, 2);
        tick(); issue(7, 9);
        tick(); idle(); commit(7, 2, 32'h11);
        tick(); idle(); set_rd(0, 7);
        sample(); lit("stale_x7", 0, 32'h11, 1'b1, 4'd9);
        check("model_pin_x7_tag", {28'd0, m_tag[7]}, 32'd9);

        // Bypass
        tick(); issue(8, 5);
        tick(); idle(); commit(8, 5, 32'h42); set_rd(1, 8);
        sample(); lit("bypass_x8", 1, 32'h42, 1'b0, 4'd0);
        tick(); idle();
        sample(); lit("after_bypass_x8", 1, 32'h42, 1'b0, 4'd0);

        // Same-cycle commit and issue
        tick(); commit(4, 1, 32'h55); issue(4, 6);
        tick(); idle(); set_rd(0, 4);
        sample(); lit("collide_x4", 0, 32'h55, 1'b1, 4'd6);

        // Flush with a simultaneous issue
        tick(); issue(10, 7);
        tick(); idle(); bus.flush_in = 1'b1; issue(9, 3);
        tick(); idle(); set_rd(0, 10); set_rd(1, 9);
        sample(); lit("flush_x10", 0, 32'h0, 1'b0, 4'd0); lit("flush_x9", 1, 32'h0, 1'b0, 4'd0);
        set_rd(0, 4);
        sample(); lit("flush_x4", 0, 32'h55, 1'b0, 4'd0);

        // Register 0
        tick(); issue(0, 1);
        tick(); idle(); set_rd(0, 0);
        sample(); lit("x0_issue", 0, 32'h0, 1'b0, 4'd0);
        tick(); commit(0, 1, 32'hFF);
        tick(); idle();
        sample(); lit("x0_commit", 0, 32'h0, 1'b0, 4'd0);

        // Stall
        tick(); bus.rdy_in = 1'b0; issue(2, 3); commit(5, 0, 32'h77);
        tick(); idle(); set_rd(0, 2); set_rd(1, 5);
        sample(); lit("stall_x2", 0, 32'h0, 1'b0, 4'd0); lit("stall_x5", 1, 32'h0, 1'b0, 4'd0);
        tick(); issue(2, 3);
        tick(); idle(); bus.rdy_in = 1'b0; commit(2, 3, 32'h99); bus.flush_in = 1'b1;
        sample(); lit("stall_nobypass_x2", 0, 32'h0, 1'b1, 4'd3);
        tick(); idle();
        sample(); lit("stall_kept_x2", 0, 32'h0, 1'b1, 4'd3);

        // Randomized traffic on a small register window for frequent collisions
        for (int n = 0; n < 3000; n++) begin
            int r;
            tick();
            rst_n             = ($urandom_range(0, 299) != 0);
            bus.rdy_in        = ($urandom_range(0, 9) != 0);
            bus.flush_in      = ($urandom_range(0, 24) == 0);
            bus.issue_en_in   = $urandom_range(0, 1) == 1;
            bus.issue_rd_in   = REGW'($urandom_range(0, 7));
            bus.issue_tag_in  = TAGW'($urandom_range(0, 15));
            r = $urandom_range(0, 7);
            bus.commit_en_in  = $urandom_range(0, 1) == 1;
            bus.commit_we_in  = ($urandom_range(0, 3) != 0);
            bus.commit_rd_in  = REGW'(r);
            bus.commit_tag_in = ($urandom_range(0, 1) == 1) ? m_tag[r] : TAGW'($urandom_range(0, 15));
            bus.commit_val_in = $urandom;
            set_rd(0, $urandom_range(0, 7));
            set_rd(1, ($urandom_range(0, 1) == 1) ? r : $urandom_range(0, 7));
        end
        tick(); idle(); rst_n = 1'b1;
        sample();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
